// File: rtl/config_loader.sv
// Configuration chain loader: takes host words and shifts them MSB-first
// into a serial configuration chain. It collects the previous chain contents
// from the chain tail as readback words while it shifts.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | word_ready high, waiting for the next host word
// SHIFT | one chain bit per cycle from the word register
// DONE  | full chain written, holds until the next start
module config_loader #(
  parameter int CHAIN_LENGTH = 96,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                  config_clock,
  input  logic                  config_nreset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  word_valid,
  input  logic [WORD_WIDTH-1:0] word_data,
  output logic                  word_ready,
  output logic                  chain_data,
  output logic                  chain_enable,
  input  logic                  chain_tail,
  output logic [WORD_WIDTH-1:0] rb_data,
  output logic                  rb_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(CHAIN_LENGTH + 1);
  localparam int IW = $clog2(WORD_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                state;
  logic                  shifting;
  logic [WORD_WIDTH-1:0] sreg;
  logic [WORD_WIDTH-1:0] rb_col;
  logic [CW-1:0]         bit_cnt;
  logic [IW-1:0]         bit_idx;
  logic [WORD_WIDTH-1:0] rb_next;
  logic                  last_bit;
  logic                  word_end;

  // Abort or reset removes the enable in the same cycle. This stops the chain
  // from taking a bit that the loader then drops.
  assign chain_enable = shifting & ~abort & config_nreset;
  assign chain_data   = chain_enable & sreg[WORD_WIDTH-1];

  assign rb_next  = {rb_col[WORD_WIDTH-2:0], chain_tail};
  assign last_bit = (bit_cnt == CW'(CHAIN_LENGTH - 1));
  assign word_end = (bit_idx == IW'(WORD_WIDTH - 1));

  // Sequencer: state, registered status outputs, shift and readback datapath.
  always_ff @(posedge config_clock) begin
    if (!config_nreset) begin
      state      <= IDLE;
      word_ready <= 1'b0;
      shifting   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rb_valid   <= 1'b0;
      rb_data    <= '0;
      rb_col     <= '0;
      sreg       <= '0;
      bit_cnt    <= '0;
      bit_idx    <= '0;
    end else begin
      rb_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start && !abort) begin
            state      <= LOAD;
            word_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            rb_col     <= '0;
          end
        end
        LOAD: begin
          if (abort) begin
            state      <= IDLE;
            word_ready <= 1'b0;
            busy       <= 1'b0;
          end else if (word_valid) begin
            state      <= SHIFT;
            sreg       <= word_data;
            word_ready <= 1'b0;
            shifting   <= 1'b1;
          end
        end
        SHIFT: begin
          if (abort) begin
            state    <= IDLE;
            shifting <= 1'b0;
            busy     <= 1'b0;
          end else begin
            sreg    <= {sreg[WORD_WIDTH-2:0], 1'b0};
            rb_col  <= rb_next;
            bit_cnt <= bit_cnt + 1'b1;
            bit_idx <= bit_idx + 1'b1;
            if (last_bit) begin
              // A short final word is left-aligned so its first bit sits at the MSB.
              state    <= DONE;
              shifting <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              rb_valid <= 1'b1;
              rb_data  <= rb_next << (IW'(WORD_WIDTH - 1) - bit_idx);
            end else if (word_end) begin
              state      <= LOAD;
              shifting   <= 1'b0;
              word_ready <= 1'b1;
              bit_idx    <= '0;
              rb_col     <= '0;
              rb_valid   <= 1'b1;
              rb_data    <= rb_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader with CHAIN_LENGTH=20 and WORD_WIDTH=8.
// It models the chain as a shift register that emits a preloaded pattern on
// its tail. It keeps queues of the expected serial bits and readback words.
module tb_config_loader;

  localparam int CL = 20;
  localparam int WW = 8;

  logic          clk = 1'b0;
  logic          nreset, start, abort, word_valid, chain_tail;
  logic [WW-1:0] word_data, rb_data;
  logic          word_ready, chain_data, chain_enable, rb_valid, busy, done;

  logic [CL-1:0] chain;
  int            checks   = 0;
  int            failures = 0;
  int            n_en     = 0;
  logic          exp_bits[$];
  logic [WW-1:0] exp_rb[$];
  logic [WW-1:0] words[3];

  always #5 clk = ~clk;

  assign chain_tail = chain[CL-1];

  config_loader #(.CHAIN_LENGTH(CL), .WORD_WIDTH(WW)) dut (
    .config_clock (clk),
    .config_nreset(nreset),
    .start        (start),
    .abort        (abort),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .word_ready   (word_ready),
    .chain_data   (chain_data),
    .chain_enable (chain_enable),
    .chain_tail   (chain_tail),
    .rb_data      (rb_data),
    .rb_valid     (rb_valid),
    .busy         (busy),
    .done         (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle. Outputs are sampled on the falling edge. The chain model
  // shifts just after the rising edge, so the DUT samples the old tail bit.
  task automatic cyc();
    logic en, d;
    @(negedge clk);
    en = chain_enable;
    d  = chain_data;
    if (en) begin
      n_en++;
      if (exp_bits.size() == 0) chk("spurious_enable", en, 0);
      else chk("chain_data", d, exp_bits.pop_front());
    end
    if (rb_valid) begin
      if (exp_rb.size() == 0) chk("spurious_rb_valid", rb_valid, 0);
      else chk("rb_data", rb_data, exp_rb.pop_front());
    end
    @(posedge clk);
    #1;
    if (en) chain = {chain[CL-2:0], d};
    if (en && n_en == CL) chk("done_after_last_bit", done, 1);
  endtask

  task automatic push_bits(input int nbits);
    logic [WW-1:0] w;
    for (int i = 0; i < nbits; i++) begin
      w = words[i / WW];
      exp_bits.push_back(w[WW - 1 - (i % WW)]);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_word_ready"}, word_ready, 0);
    chk({tag, "_chain_enable"}, chain_enable, 0);
    chk({tag, "_chain_data"}, chain_data, 0);
    chk({tag, "_rb_valid"}, rb_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rb_data"}, rb_data, 0);
  endtask

  task automatic start_load();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic send_words(input int gap, input int nwords);
    word_valid = (gap == 0);
    word_data  = words[0];
    for (int w = 0; w < nwords; w++) begin
      for (int t = 0; t < 60 && !word_ready; t++) cyc();
      chk("word_ready_wait", word_ready, 1);
      for (int g = 0; g < gap; g++) begin
        chk("gap_enable", chain_enable, 0);
        chk("gap_ready", word_ready, 1);
        cyc();
      end
      word_data  = words[w];
      word_valid = 1'b1;
      cyc();
      if (gap > 0 || w == nwords - 1) word_valid = 1'b0;
      else word_data = words[w + 1];
    end
  endtask

  task automatic full_run(input int gap);
    n_en = 0;
    exp_bits.delete();
    exp_rb.delete();
    push_bits(CL);
    exp_rb.push_back(8'h5A);
    exp_rb.push_back(8'hC3);
    exp_rb.push_back(8'h90);
    chain = 20'h5AC39;
    start_load();
    send_words(gap, 3);
    for (int t = 0; t < 40 && !done; t++) cyc();
    chk("done_reached", done, 1);
    chk("busy_in_done", busy, 0);
    chk("enable_count", n_en, CL);
    cyc();
    chk("bits_left", exp_bits.size(), 0);
    chk("rb_left", exp_rb.size(), 0);
  endtask

  initial begin
    words[0]   = 8'hA5;
    words[1]   = 8'h3C;
    words[2]   = 8'hF0;
    nreset     = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    word_valid = 1'b0;
    word_data  = '0;
    chain      = '0;
    cyc();
    cyc();
    chk_zero("por");
    nreset = 1'b1;
    cyc();

    // A word offered in IDLE is ignored.
    word_valid = 1'b1;
    word_data  = 8'hFF;
    repeat (3) cyc();
    chk("idle_valid_ready", word_ready, 0);
    chk("idle_valid_busy", busy, 0);
    chk("idle_valid_done", done, 0);
    word_valid = 1'b0;

    // Back-to-back words, then the readback pattern.
    full_run(0);

    // A word offered in DONE is ignored.
    word_valid = 1'b1;
    repeat (3) cyc();
    chk("done_valid_done", done, 1);
    chk("done_valid_ready", word_ready, 0);
    chk("done_valid_busy", busy, 0);
    word_valid = 1'b0;

    // Same load with 3-cycle valid gaps.
    full_run(3);

    // Abort after the 10th bit, with a start pulse during SHIFT.
    n_en = 0;
    exp_bits.delete();
    exp_rb.delete();
    push_bits(10);
    exp_rb.push_back(8'h5A);
    chain = 20'h5AC39;
    start_load();
    word_valid = 1'b1;
    word_data  = words[0];
    cyc();
    word_data = words[1];
    for (int t = 0; t < 60 && n_en < 10; t++) begin
      if (n_en == 9) start = 1'b1;
      cyc();
      start = 1'b0;
    end
    chk("abort_pre_count", n_en, 10);
    chk("start_in_shift_busy", busy, 1);
    chk("start_in_shift_done", done, 0);
    abort = 1'b1;
    cyc();
    abort      = 1'b0;
    word_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_enable", chain_enable, 0);
    chk("abort_ready", word_ready, 0);
    repeat (3) cyc();
    chk("abort_count", n_en, 10);
    chk("abort_bits_left", exp_bits.size(), 0);
    chk("abort_rb_left", exp_rb.size(), 0);
    full_run(0);

    // Reset held two cycles during SHIFT.
    n_en = 0;
    exp_bits.delete();
    exp_rb.delete();
    push_bits(3);
    chain = '0;
    start_load();
    word_valid = 1'b1;
    word_data  = words[0];
    cyc();
    word_valid = 1'b0;
    repeat (3) cyc();
    chk("rst_pre_count", n_en, 3);
    nreset = 1'b0;
    cyc();
    chk_zero("rst1");
    cyc();
    chk_zero("rst2");
    nreset = 1'b1;
    repeat (2) cyc();
    chk("rst_idle_busy", busy, 0);
    chk("rst_idle_ready", word_ready, 0);
    chk("rst_count", n_en, 3);
    chk("rst_bits_left", exp_bits.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
